cache_arbiter_rr: RTL



---
 rtl/cache_arbiter_rr.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_arbiter_rr.sv
// Round-robin arbiter between NUM_PORTS cache miss ports and one line-wide memory bus.
// Define ARB_PREFETCH_EN to add a next-line prefetch into a one-line read buffer.

module cache_arbiter_rr_checker #(
  parameter int NUM_PORTS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  input logic [NUM_PORTS-1:0] req_read,
  input logic [NUM_PORTS-1:0] req_write
);
  // A port never asks for a read and a write of its line at the same time.
  rw_exclusive_a: assert property (@(posedge clk) disable iff (!rst_n)
    (req_read & req_write) == '0);
endmodule

module cache_arbiter_rr #(
  parameter int NUM_PORTS  = 2,
  parameter int LINE_BITS  = 256,
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           req_read,
  input  logic [NUM_PORTS-1:0]           req_write,
  input  logic [NUM_PORTS*ADDR_W-1:0]    req_addr,
  input  logic [NUM_PORTS*LINE_BITS-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]           req_resp,
  output logic [LINE_BITS-1:0]           req_rdata,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [LINE_BITS-1:0]           mem_wdata,
  input  logic [LINE_BITS-1:0]           mem_rdata,
  input  logic                           mem_resp
);

  localparam int                GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));
  localparam logic [GW-1:0]     LAST_PORT = GW'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE    = 2'd1,
    PREFETCH = 2'd2,
    PF_HIT   = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

  function automatic logic [GW-1:0] next_port(input logic [GW-1:0] p);
    return (p == LAST_PORT) ? '0 : p + GW'(1);
  endfunction

  state_e               state_q, state_d;
  logic [GW-1:0]        rr_q, rr_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]    last_addr_q, last_addr_d;

  logic [NUM_PORTS-1:0] active_s;
  logic [NUM_PORTS-1:0] req_resp_s;
  logic [LINE_BITS-1:0] req_rdata_s;
  logic                 pick_found_s;
  logic [GW-1:0]        pick_idx_s;
  logic                 pick_write_s;
  logic [ADDR_W-1:0]    pick_addr_s;
  logic [LINE_BITS-1:0] pick_wdata_s;

`ifdef ARB_PREFETCH_EN
  logic                 pf_pending_q, pf_pending_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0]    buf_addr_q, buf_addr_d;
  logic [LINE_BITS-1:0] buf_data_q, buf_data_d;
  logic                 buf_hit_s;
`endif

  assign active_s = req_read | req_write;

  // Round-robin search: first active port at or after rr_q, wrapping.
  always_comb begin
    logic [GW-1:0] cand;
    logic          take;
    pick_found_s = 1'b0;
    pick_idx_s   = rr_q;
    cand         = rr_q;
    take         = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      take         = !pick_found_s && active_s[cand];
      pick_idx_s   = take ? cand : pick_idx_s;
      pick_found_s = pick_found_s | take;
      cand         = next_port(cand);
    end
  end

  // Write wins when a port illegally raises both commands.
  assign pick_write_s = req_write[pick_idx_s];
  assign pick_addr_s  = line_align(req_addr[int'(pick_idx_s)*ADDR_W +: ADDR_W]);
  assign pick_wdata_s = req_wdata[int'(pick_idx_s)*LINE_BITS +: LINE_BITS];

`ifdef ARB_PREFETCH_EN
  assign buf_hit_s = buf_valid_q && (buf_addr_q == pick_addr_s);
`endif

  // Next-state, command registers and completion strobe.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    last_addr_d = last_addr_q;
    req_resp_s  = '0;
    req_rdata_s = '0;
`ifdef ARB_PREFETCH_EN
    pf_pending_d = pf_pending_q;
    buf_valid_d  = buf_valid_q;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found_s) begin
          grant_d     = pick_idx_s;
          state_d     = SERVE;
          mem_read_d  = !pick_write_s;
          mem_write_d = pick_write_s;
          mem_addr_d  = pick_addr_s;
          mem_wdata_d = pick_wdata_s;
`ifdef ARB_PREFETCH_EN
          // Reads of the buffered line complete locally; writes to it kill it.
          if (!pick_write_s && buf_hit_s) begin
            state_d     = PF_HIT;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
          end else begin
            buf_valid_d = buf_valid_q && !(pick_write_s && buf_hit_s);
          end
`endif
        end
`ifdef ARB_PREFETCH_EN
        else if (pf_pending_q) begin
          state_d     = PREFETCH;
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = line_align(last_addr_q + ADDR_W'(LINE_BYTES));
        end
`endif
        else begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        if (mem_resp) begin
          req_resp_s[grant_q] = 1'b1;
          req_rdata_s         = mem_rdata;
          rr_d                = next_port(grant_q);
          mem_read_d          = 1'b0;
          mem_write_d         = 1'b0;
          state_d             = IDLE;
          if (mem_read_q) begin
            last_addr_d = mem_addr_q;
`ifdef ARB_PREFETCH_EN
            pf_pending_d = 1'b1;
`endif
          end else begin
            last_addr_d = last_addr_q;
          end
        end else begin
          state_d = SERVE;
        end
      end
      PREFETCH: begin
`ifdef ARB_PREFETCH_EN
        if (mem_resp) begin
          buf_valid_d  = 1'b1;
          buf_addr_d   = mem_addr_q;
          buf_data_d   = mem_rdata;
          pf_pending_d = 1'b0;
          mem_read_d   = 1'b0;
          state_d      = IDLE;
        end else begin
          state_d = PREFETCH;
        end
`else
        state_d = IDLE;
`endif
      end
      PF_HIT: begin
`ifdef ARB_PREFETCH_EN
        req_resp_s[grant_q] = 1'b1;
        req_rdata_s         = buf_data_q;
        rr_d                = next_port(grant_q);
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      last_addr_q <= last_addr_d;
    end
  end

`ifdef ARB_PREFETCH_EN
  // Prefetch buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pf_pending_q <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= '0;
      buf_data_q   <= '0;
    end else begin
      pf_pending_q <= pf_pending_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
    end
  end
`endif

  assign req_resp    = req_resp_s;
  assign req_rdata   = req_rdata_s;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

  cache_arbiter_rr_checker #(
    .NUM_PORTS (NUM_PORTS)
  ) u_checker (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_read  (req_read),
    .req_write (req_write)
  );

endmodule
